// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline boundary with a valid/ready handshake and a 2-entry skid buffer.
// ex_ready is decoded from registered state only, so MEM back-pressure never
// forms a combinational path into EX. A bubble never writes data memory.
module ex_mem_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_dm_we,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [DATA_W-1:0] ex_muxb,
  input  logic [ADDR_W-1:0] ex_dm_addr,
  input  logic [SEL_W-1:0]  ex_rf_d_sel,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_dm_we,
  output logic [DATA_W-1:0] mem_alu_res,
  output logic [DATA_W-1:0] mem_muxb,
  output logic [ADDR_W-1:0] mem_dm_addr,
  output logic [SEL_W-1:0]  mem_rf_d_sel,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              dm_we;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] muxb;
    logic [ADDR_W-1:0] dm_addr;
    logic [SEL_W-1:0]  rf_d_sel;
  } entry_t;

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state;
  entry_t main_q, skid_q, in_e;
  logic   push, pop;

  assign in_e = '{dm_we: ex_dm_we, alu_res: ex_alu_res, muxb: ex_muxb,
                  dm_addr: ex_dm_addr, rf_d_sel: ex_rf_d_sel};

  assign ex_ready  = !rst && (state != TWO);
  assign mem_valid = (state != EMPTY);
  assign push      = ex_valid & ex_ready;
  assign pop       = mem_valid & mem_ready;
  assign occupancy = state;

  assign mem_dm_we    = main_q.dm_we & mem_valid;
  assign mem_alu_res  = main_q.alu_res;
  assign mem_muxb     = main_q.muxb;
  assign mem_dm_addr  = main_q.dm_addr;
  assign mem_rf_d_sel = main_q.rf_d_sel;

  // Occupancy state machine; flush squashes everything held and incoming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY:   if (push) state <= ONE;
        ONE:     if (push && !pop) state <= TWO;
                 else if (!push && pop) state <= EMPTY;
        TWO:     if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  // Entry storage; not cleared on pop or flush, and a flushed push never loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      case (state)
        EMPTY: if (push) main_q <= in_e;
        ONE: begin
          if (push && pop)       main_q <= in_e;
          else if (push && !pop) skid_q <= in_e;
        end
        TWO:     if (pop) main_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed testbench for ex_mem_skid: reset, streaming, stall/skid, write
// gating, flush and asynchronous reset mid-stall.
module tb_ex_mem_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_dm_we = 1'b0;
  logic [31:0] ex_alu_res = '0;
  logic [31:0] ex_muxb = '0;
  logic [15:0] ex_dm_addr = '0;
  logic [1:0]  ex_rf_d_sel = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_dm_we;
  logic [31:0] mem_alu_res;
  logic [31:0] mem_muxb;
  logic [15:0] mem_dm_addr;
  logic [1:0]  mem_rf_d_sel;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  // status = {ex_ready, mem_valid, mem_dm_we, occupancy}
  logic [4:0] status;
  assign status = {ex_ready, mem_valid, mem_dm_we, occupancy};

  ex_mem_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_dm_we(ex_dm_we), .ex_alu_res(ex_alu_res), .ex_muxb(ex_muxb),
    .ex_dm_addr(ex_dm_addr), .ex_rf_d_sel(ex_rf_d_sel),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dm_we(mem_dm_we),
    .mem_alu_res(mem_alu_res), .mem_muxb(mem_muxb), .mem_dm_addr(mem_dm_addr),
    .mem_rf_d_sel(mem_rf_d_sel), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] alu);
    ex_valid    = v;
    ex_dm_we    = we;
    ex_alu_res  = alu;
    ex_muxb     = ~alu;
    ex_dm_addr  = alu[15:0] + 16'h100;
    ex_rf_d_sel = alu[1:0];
  endtask

  task automatic test_reset();
    ex_valid    = 1'b1;
    ex_dm_we    = 1'b1;
    ex_alu_res  = $urandom;
    ex_muxb     = $urandom;
    ex_dm_addr  = 16'($urandom);
    ex_rf_d_sel = 2'($urandom);
    mem_ready   = 1'b1;
    repeat (3) tick();
    checks++;
    if (status !== 5'b00000) begin
      errors++; $display("FAIL reset_status: got %b expected %b", status, 5'b00000);
    end
    checks++;
    if ({mem_alu_res, mem_muxb, mem_dm_addr, mem_rf_d_sel} !== 82'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h/%h expected all 0",
                         mem_alu_res, mem_muxb, mem_dm_addr, mem_rf_d_sel);
    end
    drive(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    checks++;
    if (status !== 5'b10000) begin
      errors++; $display("FAIL reset_release: got %b expected %b", status, 5'b10000);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, vals[i]);
      tick();
      checks++;
      if (mem_alu_res !== vals[i] || status !== 5'b11001) begin
        errors++; $display("FAIL stream_%0d: got alu=%h st=%b expected alu=%h st=%b",
                           i, mem_alu_res, status, vals[i], 5'b11001);
      end
    end
    checks++;
    if (mem_muxb !== ~32'h33 || mem_dm_addr !== 16'h133 || mem_rf_d_sel !== 2'b11) begin
      errors++; $display("FAIL stream_fields: got muxb=%h addr=%h sel=%h expected %h/%h/%h",
                         mem_muxb, mem_dm_addr, mem_rf_d_sel, ~32'h33, 16'h133, 2'b11);
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if (status !== 5'b10000) begin
      errors++; $display("FAIL stream_drain: got %b expected %b", status, 5'b10000);
    end
  endtask

  task automatic test_stall();
    mem_ready = 1'b1;
    drive(1'b1, 1'b0, 32'hA1);
    tick();
    drive(1'b1, 1'b0, 32'hB2);
    mem_ready = 1'b0;
    tick();
    checks++;
    if (status !== 5'b01010 || mem_alu_res !== 32'hA1) begin
      errors++; $display("FAIL stall_two: got st=%b alu=%h expected st=%b alu=%h",
                         status, mem_alu_res, 5'b01010, 32'hA1);
    end
    drive(1'b1, 1'b0, 32'hC3);
    tick();
    checks++;
    if (status !== 5'b01010 || mem_alu_res !== 32'hA1) begin
      errors++; $display("FAIL stall_hold: got st=%b alu=%h expected st=%b alu=%h",
                         status, mem_alu_res, 5'b01010, 32'hA1);
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (status !== 5'b11001 || mem_alu_res !== 32'hB2) begin
      errors++; $display("FAIL stall_release_b: got st=%b alu=%h expected st=%b alu=%h",
                         status, mem_alu_res, 5'b11001, 32'hB2);
    end
    tick();
    checks++;
    if (status !== 5'b11001 || mem_alu_res !== 32'hC3) begin
      errors++; $display("FAIL stall_release_c: got st=%b alu=%h expected st=%b alu=%h",
                         status, mem_alu_res, 5'b11001, 32'hC3);
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if (status !== 5'b10000) begin
      errors++; $display("FAIL stall_drain: got %b expected %b", status, 5'b10000);
    end
  endtask

  task automatic test_write_gating();
    mem_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h44);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (status !== 5'b11101) begin
      errors++; $display("FAIL gate_loaded: got %b expected %b", status, 5'b11101);
    end
    tick();
    checks++;
    if (status !== 5'b11101) begin
      errors++; $display("FAIL gate_held: got %b expected %b", status, 5'b11101);
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (status !== 5'b10000 || mem_alu_res !== 32'h44) begin
      errors++; $display("FAIL gate_empty: got st=%b alu=%h expected st=%b alu=%h",
                         status, mem_alu_res, 5'b10000, 32'h44);
    end
  endtask

  task automatic test_flush();
    mem_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h55);
    tick();
    drive(1'b1, 1'b1, 32'h66);
    tick();
    checks++;
    if (status !== 5'b01110) begin
      errors++; $display("FAIL flush_fill: got %b expected %b", status, 5'b01110);
    end
    flush = 1'b1;
    drive(1'b1, 1'b1, 32'h77);
    tick();
    flush = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (status !== 5'b10000) begin
      errors++; $display("FAIL flush_empty: got %b expected %b", status, 5'b10000);
    end
    mem_ready = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (mem_valid !== 1'b0 || mem_alu_res === 32'h66 || mem_alu_res === 32'h77) begin
        errors++; $display("FAIL flush_no_reappear: got valid=%b alu=%h expected valid=0 alu=55",
                           mem_valid, mem_alu_res);
      end
    end
  endtask

  task automatic test_async_reset();
    mem_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h88);
    tick();
    drive(1'b1, 1'b0, 32'h99);
    tick();
    drive(1'b0, 1'b0, 32'h0);
    checks++;
    if (status !== 5'b01110) begin
      errors++; $display("FAIL areset_fill: got %b expected %b", status, 5'b01110);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (status !== 5'b00000 || mem_alu_res !== 32'h0 || mem_dm_addr !== 16'h0) begin
      errors++; $display("FAIL areset_immediate: got st=%b alu=%h addr=%h expected st=%b alu=0 addr=0",
                         status, mem_alu_res, mem_dm_addr, 5'b00000);
    end
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    drive(1'b1, 1'b0, 32'hAA);
    tick();
    checks++;
    if (status !== 5'b11001 || mem_alu_res !== 32'hAA) begin
      errors++; $display("FAIL areset_first_push: got st=%b alu=%h expected st=%b alu=%h",
                         status, mem_alu_res, 5'b11001, 32'hAA);
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if (status !== 5'b10000) begin
      errors++; $display("FAIL areset_drain: got %b expected %b", status, 5'b10000);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_write_gating();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
# ex_mem_skid

Parametrised EX/MEM pipeline boundary with a valid/ready handshake and a 2-entry skid buffer. It sits between the execute stage and the memory stage and carries the data-memory write enable, ALU result, store operand, data-memory address and register-file write-data select. Compared with a plain EX/MEM register, it adds:
- stall back-pressure from MEM without a combinational ready path,
- a synchronous flush for branch/exception squash,
- write-enable gating so a bubble never writes data memory.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and store operand
- ADDR_W, 16, width of data-memory address
- SEL_W, 2, width of register-file write-data select

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all held and incoming entries
- ex_valid  in  1  EX presents a valid entry
- ex_ready  out  1  block can accept an entry this cycle
- ex_dm_we  in  1  data-memory write enable of EX entry
- ex_alu_res  in  DATA_W  ALU result
- ex_muxb  in  DATA_W  store operand
- ex_dm_addr  in  ADDR_W  data-memory address
- ex_rf_d_sel  in  SEL_W  register-file write-data select
- mem_valid  out  1  output entry valid
- mem_ready  in  1  MEM consumes the output entry this cycle
- mem_dm_we  out  1  gated write enable (main_dm_we AND mem_valid)
- mem_alu_res  out  DATA_W  ALU result of output entry
- mem_muxb  out  DATA_W  store operand of output entry
- mem_dm_addr  out  ADDR_W  address of output entry
- mem_rf_d_sel  out  SEL_W  select of output entry
- occupancy  out  2  entries held: 0, 1 or 2

## Operation
- Storage:
  - main register drives mem_* outputs.
  - skid register holds one overflow entry.
  - Each register holds dm_we, alu_res, muxb, dm_addr and rf_d_sel.
- Transfers:
  - push = ex_valid & ex_ready.
  - pop = mem_valid & mem_ready.
- State equals occupancy: EMPTY(0), ONE(1), TWO(2).
- EMPTY:
  - push -> main loads input; go to ONE.
  - No push -> stay EMPTY.
- ONE:
  - push & pop -> main loads input; stay ONE.
  - push & !pop -> skid loads input; go to TWO.
  - !push & pop -> go to EMPTY.
  - Neither -> hold.
- TWO:
  - pop -> main loads skid; go to ONE.
  - Otherwise hold. ex_ready=0, so push cannot occur.
- Outputs:
  - ex_ready = !rst & (state != TWO), decoded from state only.
  - mem_valid = (state != EMPTY).
- Flush has highest priority:
  - state -> EMPTY; mem_valid and mem_dm_we are 0 next cycle.
  - A same-cycle push is handshaken but discarded.
  - A same-cycle pop still completes on the current output.
- Data registers are not cleared on pop or flush. Outputs hold their last value while EMPTY; only mem_dm_we and mem_valid are forced low.
- Reset (asynchronous):
  - state = EMPTY, occupancy = 0, mem_valid = 0, mem_dm_we = 0.
  - All data outputs and skid contents = 0.
  - ex_ready = 0 while rst is high, 1 from the first cycle after release.
- Reset mid-operation: both entries are lost immediately and no write enable is emitted.

## Timing
- Latency 1 cycle: an entry pushed at edge N appears on mem_* after edge N when it is loaded into main.
- Throughput 1 entry/cycle with mem_ready held high. The skid is never used in that case.
- No combinational path from mem_ready or mem_valid to ex_ready; ex_ready depends only on registered state and rst.
- When mem_ready drops, the in-flight entry lands in skid. ex_ready falls the following cycle and no entry is lost.
- When mem_ready rises in TWO:
  - Main is popped and skid moves to main on the same edge.
  - ex_ready rises one cycle later.
- Entry order is strictly FIFO; no reordering and no duplication.

## Test plan
- Reset: assert rst with random inputs and ex_valid=1 -> ex_ready=0, mem_valid=0, mem_dm_we=0, all mem_* = 0, occupancy=0. Release -> ex_ready=1 next cycle.
- Streaming: mem_ready=1, push entries A=0x11, B=0x22, C=0x33 (alu_res) on consecutive cycles -> mem_alu_res shows 0x11, 0x22, 0x33 one cycle after each push; occupancy never exceeds 1.
- Stall/skid: push A, B, C while mem_ready=0 from the cycle after A -> occupancy 2, ex_ready=0, C held upstream. Raise mem_ready -> outputs A, B, C in order with no loss and no duplicate.
- Write gating: push entry with ex_dm_we=1, then idle -> mem_dm_we=1 for exactly the cycles that entry is valid and unpopped; 0 when EMPTY, even though the data outputs hold.
- Flush: with occupancy 2, assert flush together with ex_valid=1 -> next cycle occupancy=0, mem_valid=0, mem_dm_we=0; the flushed and incoming entries never appear.
- Async reset mid-stall: occupancy 2, assert rst between clock edges -> outputs clear immediately without a clock edge; after release the first push appears normally.
